// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register map, vector layout
// and the controller's FSM states.
package irq_pkg;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_VECTOR  = 2'd2;
   localparam logic [1:0] REG_EOI     = 2'd3;

   localparam int VEC_VALID_BIT = 31;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector, one lane per bit.
// rise_o is a single-cycle pulse per 0->1 transition seen after synchronization.
module irq_sync_edge #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] sync1_q;
   logic [W-1:0] sync2_q;
   logic [W-1:0] prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches source edges into PENDING, raises
// irq for the highest-priority enabled source and holds off until EOI.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src,
   input  logic            sel,
   input  logic [31:0]     adr,
   input  logic [31:0]     writedata,
   input  logic            memwrite,
   output logic [31:0]     readdata,
   output logic            irq,
   input  logic            iack
);

   irq_state_t      state_q, state_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic            vec_valid_q, vec_valid_d;
   logic [4:0]      vec_id_q, vec_id_d;
   logic            irq_q;

   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] active;
   logic [NSRC-1:0] win_oh;
   logic [4:0]      winner;
   logic            wr_en, wr_pend, wr_mask, wr_eoi, take;
   logic            unused_bits;

   irq_sync_edge #(.W(NSRC)) u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .d_i    (src),
      .rise_o (rise)
   );

   assign unused_bits = ^{adr[31:4], adr[1:0], writedata[31:NSRC]};

   assign wr_en   = sel & memwrite;
   assign wr_pend = wr_en && (adr[3:2] == REG_PENDING);
   assign wr_mask = wr_en && (adr[3:2] == REG_MASK);
   assign wr_eoi  = wr_en && (adr[3:2] == REG_EOI);

   assign active = pend_q & mask_q;

   // Descending scan so the lowest set index wins.
   always_comb begin
      winner = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) winner = 5'(i);
      end
   end

   assign win_oh = NSRC'(1) << winner;
   assign take   = (state_q == ASSERT) && (active != '0) && iack;

   always_comb begin
      state_d     = state_q;
      vec_valid_d = vec_valid_q;
      vec_id_d    = vec_id_q;
      case (state_q)
         IDLE: begin
            if (active != '0) state_d = ASSERT;
         end
         ASSERT: begin
            if (active == '0) begin
               state_d = IDLE;
            end else if (iack) begin
               state_d     = SERVICE;
               vec_valid_d = 1'b1;
               vec_id_d    = winner;
            end
         end
         SERVICE: begin
            if (wr_eoi) begin
               state_d     = IDLE;
               vec_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // New edges are OR-ed in last so they win over W1C and iack clears.
   always_comb begin
      pend_d = pend_q;
      if (wr_pend) pend_d = pend_d & ~writedata[NSRC-1:0];
      if (take)    pend_d = pend_d & ~win_oh;
      pend_d = pend_d | rise;
   end

   assign mask_d = wr_mask ? writedata[NSRC-1:0] : mask_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         mask_q      <= '0;
         vec_valid_q <= 1'b0;
         vec_id_q    <= '0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         vec_valid_q <= vec_valid_d;
         vec_id_q    <= vec_id_d;
         irq_q       <= (state_d == ASSERT);
      end
   end

   assign irq = irq_q;

   always_comb begin
      readdata = '0;
      if (sel) begin
         case (adr[3:2])
            REG_PENDING: readdata = 32'(pend_q);
            REG_MASK:    readdata = 32'(mask_q);
            REG_VECTOR: begin
               readdata[VEC_VALID_BIT] = vec_valid_q;
               readdata[4:0]           = vec_id_q;
            end
            default:     readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, checked against a
// cycle-level behavioural model through an expected-read queue and an irq monitor.
module tb_irq_ctrl;

   localparam int NSRC = 8;
   localparam int M_IDLE = 0;
   localparam int M_ASSERT = 1;
   localparam int M_SERVICE = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NSRC-1:0] src = '0;
   logic            sel = 1'b0;
   logic [31:0]     adr = '0;
   logic [31:0]     writedata = '0;
   logic            memwrite = 1'b0;
   logic [31:0]     readdata;
   logic            irq;
   logic            iack = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   irq_ctrl #(.NSRC(NSRC)) dut (
      .clk       (clk),
      .reset     (reset),
      .src       (src),
      .sel       (sel),
      .adr       (adr),
      .writedata (writedata),
      .memwrite  (memwrite),
      .readdata  (readdata),
      .irq       (irq),
      .iack      (iack)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   int unsigned m_pend, m_mask, m_vid, m_mode;
   bit          m_vvalid, m_irq;
   int unsigned s1, s2, s3;

   function automatic logic [31:0] m_reg(input logic [1:0] a);
      case (a)
         2'd0: return m_pend;
         2'd1: return m_mask;
         2'd2: return (m_vvalid ? 32'h8000_0000 : 32'h0) | m_vid;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      int unsigned ev, act, win, np;
      bit wr;
      if (!reset) begin
         m_pend = 0; m_mask = 0; m_vid = 0; m_vvalid = 0; m_mode = M_IDLE; m_irq = 0;
         s1 = 0; s2 = 0; s3 = 0;
      end else begin
         ev  = s2 & ~s3;
         s3  = s2; s2 = s1; s1 = src;
         act = m_pend & m_mask;
         win = (act == 0) ? 0 : $clog2(act & (~act + 1));
         wr  = sel && memwrite;
         np  = m_pend;
         if (wr && adr[3:2] == 2'd0) np = np & ~writedata;
         if (m_mode == M_IDLE) begin
            if (act != 0) m_mode = M_ASSERT;
         end else if (m_mode == M_ASSERT) begin
            if (act == 0) m_mode = M_IDLE;
            else if (iack) begin
               m_mode = M_SERVICE; m_vvalid = 1; m_vid = win;
               np = np & ~(32'd1 << win);
            end
         end else if (wr && adr[3:2] == 2'd3) begin
            m_mode = M_IDLE; m_vvalid = 0;
         end
         m_pend = (np | ev) & 32'hFF;
         if (wr && adr[3:2] == 2'd1) m_mask = writedata & 32'hFF;
         m_irq = (m_mode == M_ASSERT);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      n_checks++;
      if (irq !== m_irq) begin
         n_errors++;
         $display("FAIL irq t=%0t got %b exp %b", $time, irq, m_irq);
      end
      if (sel && !memwrite) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL rd_unexpected t=%0t got %h exp none", $time, readdata);
         end else begin
            e = exp_q.pop_front();
            if (readdata !== e) begin
               n_errors++;
               $display("FAIL rd adr=%0d t=%0t got %h exp %h", adr[3:2], $time, readdata, e);
            end
         end
      end else if (!sel) begin
         n_checks++;
         if (readdata !== 32'h0) begin
            n_errors++;
            $display("FAIL rd_unselected t=%0t got %h exp 0", $time, readdata);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input bit s, input bit w, input logic [1:0] a, input logic [31:0] d,
                        input bit ack, input bit use_c, input logic [31:0] c);
      @(posedge clk);
      #1;
      sel       = s;
      memwrite  = w;
      adr       = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
      writedata = d;
      iack      = ack;
      if (s && !w) exp_q.push_back(use_c ? c : m_reg(a));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 2'($urandom_range(0, 3)), $urandom(), 0, 0, 0);
   endtask

   task automatic rd_c(input logic [1:0] a, input logic [31:0] c);
      drive(1, 0, a, $urandom(), 0, 1, c);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      drive(1, 1, a, d, 0, 0, 0);
   endtask

   task automatic ack_pulse();
      drive(0, 0, 2'd0, $urandom(), 1, 0, 0);
   endtask

   task automatic chk_irq(input logic exp, input string name);
      @(negedge clk);
      n_checks++;
      if (irq !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t irq got %b exp %b", name, $time, irq, exp);
      end
   endtask

   int hold[NSRC];

   initial begin
      #23 reset = 1'b1;

      // Reset values
      rd_c(2'd0, 0); rd_c(2'd1, 0); rd_c(2'd2, 0); rd_c(2'd3, 0);
      idle(1); chk_irq(0, "reset_irq");

      // Single source latency and acknowledge
      wr(2'd1, 32'h01);
      src = 8'h01;
      rd_c(2'd0, 0); chk_irq(0, "t1_k");
      rd_c(2'd0, 0);
      rd_c(2'd0, 32'h01); chk_irq(0, "t1_k2");
      idle(1); chk_irq(1, "t1_k3");
      ack_pulse(); chk_irq(1, "t1_ack_slot");
      rd_c(2'd2, 32'h8000_0000); chk_irq(0, "t1_after_ack");
      rd_c(2'd0, 0);
      wr(2'd3, 0);
      idle(1); chk_irq(0, "t1_after_eoi");
      src = 8'h00;

      // Priority between two simultaneous sources, EOI gap
      wr(2'd1, 32'hFF);
      src = 8'h24;
      idle(4); chk_irq(1, "t2_assert");
      ack_pulse();
      rd_c(2'd2, 32'h8000_0002); chk_irq(0, "t2_service");
      rd_c(2'd0, 32'h20);
      wr(2'd3, $urandom());
      idle(1); chk_irq(0, "t2_gap");
      idle(1); chk_irq(1, "t2_reassert");
      ack_pulse();
      rd_c(2'd2, 32'h8000_0005);
      rd_c(2'd0, 0);
      wr(2'd3, 0);
      idle(1); chk_irq(0, "t2_done");
      src = 8'h00;

      // Masked pending, late enable, withdrawal by mask
      wr(2'd1, 0);
      src = 8'h08;
      idle(4); chk_irq(0, "t3_masked");
      rd_c(2'd0, 32'h08);
      wr(2'd1, 32'h08);
      idle(1); chk_irq(0, "t3_mask_t");
      idle(1); chk_irq(1, "t3_mask_t1");
      wr(2'd1, 0);
      idle(1); chk_irq(1, "t3_unmask_t");
      idle(1); chk_irq(0, "t3_unmask_t1");
      rd_c(2'd0, 32'h08);
      wr(2'd0, 32'h08);
      rd_c(2'd0, 0);
      src = 8'h00;

      // New edge beats W1C
      src = 8'h02; idle(2); src = 8'h00; idle(3);
      rd_c(2'd0, 32'h02);
      src = 8'h02; idle(1);
      wr(2'd0, 32'h02);
      rd_c(2'd0, 32'h02);
      wr(2'd0, 32'h02);
      rd_c(2'd0, 0);
      src = 8'h00;

      // New edge beats iack clear on the winner
      wr(2'd1, 32'h10);
      src = 8'h10; idle(2); src = 8'h00; idle(2); src = 8'h10; idle(1);
      ack_pulse(); chk_irq(1, "t4_ack_slot");
      rd_c(2'd2, 32'h8000_0004); chk_irq(0, "t4_service");
      rd_c(2'd0, 32'h10);
      wr(2'd3, 0);
      idle(1); chk_irq(0, "t4_gap");
      idle(1); chk_irq(1, "t4_reassert");
      ack_pulse();
      rd_c(2'd2, 32'h8000_0004);
      rd_c(2'd0, 0);
      wr(2'd3, 0);
      src = 8'h00;
      idle(1);

      // Extra iack and double EOI
      wr(2'd1, 32'h30);
      src = 8'h30;
      idle(4); chk_irq(1, "t5_assert");
      ack_pulse();
      ack_pulse();
      rd_c(2'd0, 32'h20);
      rd_c(2'd2, 32'h8000_0004);
      wr(2'd3, 0);
      wr(2'd3, 0);
      idle(1); chk_irq(1, "t5_reassert");
      rd_c(2'd2, 32'h0000_0004);

      // Asynchronous reset while in ASSERT
      src = 8'h00;
      idle(1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset irq got %b exp 0", irq);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      rd_c(2'd0, 0); rd_c(2'd1, 0); rd_c(2'd2, 0); rd_c(2'd3, 0);
      idle(1); chk_irq(0, "post_reset_irq");

      // Random traffic
      for (int b = 0; b < NSRC; b++) hold[b] = 0;
      for (int n = 0; n < 1600; n++) begin
         int op;
         bit ack;
         if (n == 800) begin
            idle(1);
            @(posedge clk);
            #3 reset = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            #1 reset = 1'b1;
         end
         op  = $urandom_range(0, 9);
         ack = (m_irq && $urandom_range(0, 3) == 0) || op == 9;
         case (op)
            4, 5:    drive(1, 0, 2'($urandom_range(0, 3)), $urandom(), ack, 0, 0);
            6:       drive(1, 1, 2'd1, $urandom(), ack, 0, 0);
            7:       drive(1, 1, 2'd0, $urandom(), ack, 0, 0);
            8:       drive(1, 1, 2'd3, $urandom(), ack, 0, 0);
            default: drive(0, 0, 2'($urandom_range(0, 3)), $urandom(), ack, 0, 0);
         endcase
         for (int b = 0; b < NSRC; b++) begin
            hold[b]++;
            if (hold[b] >= 2 && $urandom_range(0, 7) == 0) begin
               src[b]  = ~src[b];
               hold[b] = 0;
            end
         end
      end
      idle(3);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL exp_q_leftover got %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller that drives the multicycle MIPS core's `irq` input and consumes its `iack` pulse. It collects up to `NSRC` asynchronous peripheral sources (video vblank, keyboard, timer, …) and latches their rising edges into a pending register. It masks and prioritises them, holds `irq` until the core acknowledges, then blocks further requests until software writes end-of-interrupt. It sits on the core's data bus next to RAM and the video character map, selected by the system address decoder.

## Interface
Parameters:
- `NSRC`, 8: number of interrupt sources, 1..31; source 0 has the highest priority.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; the block is in reset while `reset`=0.
- `src`  in  NSRC  raw source levels, asynchronous to `clk`; an event is a 0→1 transition.
- `sel`  in  1  chip select from the address decoder.
- `adr`  in  32  bus address; only `adr[3:2]` is decoded.
- `writedata`  in  32  bus write data.
- `memwrite`  in  1  bus write strobe; a write occurs when `sel` and `memwrite` are both 1 at a clock edge.
- `readdata`  out  32  register read data; combinational from `sel` and `adr[3:2]`; 0 when `sel`=0.
- `irq`  out  1  interrupt request to the core; registered.
- `iack`  in  1  one-cycle acknowledge pulse from the core.

## Operation
- Register map, selected by `adr[3:2]`:
  - 0 PENDING: read/write-1-to-clear, bits [NSRC-1:0].
  - 1 MASK: read/write, 1 = enabled.
  - 2 VECTOR: read-only; bit 31 = in-service valid, bits [4:0] = in-service source id.
  - 3 EOI: write-only, any data; reads return 0.
- Reads of bits at or above NSRC return 0. Writes to those bits have no effect.
- Each `src` bit passes through a 2-flop synchronizer, then rising-edge detect (`sync2 & ~prev`). A detected edge sets the matching PENDING bit.
- `active = PENDING & MASK`. `winner` = lowest-index set bit of `active`.
- FSM states:
  - IDLE: `irq`=0. Goes to ASSERT when `active`≠0.
  - ASSERT: `irq`=1. Goes to IDLE when `active` becomes 0 (mask write or W1C withdrew the request). On `iack`=1: VECTOR ← {1, `winner`}, PENDING[`winner`] cleared, go to SERVICE. The winner is evaluated in the same cycle as `iack`.
  - SERVICE: `irq`=0. Pending edges keep accumulating. An EOI write sets VECTOR[31] ← 0 and goes to IDLE; VECTOR[4:0] keeps the last id.
- `iack` outside ASSERT is ignored. EOI writes outside SERVICE are ignored.
- Simultaneous events on the same PENDING bit in one cycle:
  - a new edge beats a W1C clear;
  - a new edge beats an `iack` clear.
  In both cases the bit stays 1.
- Reset values: PENDING=0, MASK=0, VECTOR=0, state IDLE, `irq`=0, synchronizer and `prev` flops 0. `readdata` is 0 unless `sel`=1.
- Reset assertion mid-operation: everything returns to reset values immediately and asynchronously. Edges that arrive during reset are lost.

## Timing
- `src` first sampled high at edge k:
  - PENDING bit = 1 after edge k+2;
  - `irq` = 1 after edge k+3, if the bit is masked-in.
- `iack` high at edge t: `irq` = 0 after t, and VECTOR is readable in cycle t+1.
- EOI write at edge t: state is IDLE after t. If `active`≠0, `irq` = 1 again after t+1. This gives a minimum 1-cycle `irq` low gap.
- MASK write at edge t takes effect on the FSM at edge t+1.
- `readdata` reflects register contents with zero added latency. It shows the state as of the last clock edge.
- A `src` pulse shorter than one `clk` period may be missed; sources must hold their level ≥2 cycles.

## Structure
- Package `irq_pkg` holds:
  - the register index constants `REG_PENDING`=0, `REG_MASK`=1, `REG_VECTOR`=2, `REG_EOI`=3;
  - the FSM enum `irq_state_t` {IDLE, ASSERT, SERVICE};
  - the `VEC_VALID_BIT`=31 constant.
- One sub-module, `irq_sync_edge`, is parameterised by width and contains the 2-flop synchronizer, the `prev` flop and the rising-edge detect. `irq_ctrl` instantiates it once with width NSRC.

## Test plan
- Reset, then write MASK=0x01 and raise `src[0]` at edge k → PENDING=0x01 after k+2, `irq`=1 after k+3. Pulse `iack` → `irq`=0, VECTOR=0x8000_0000, PENDING=0x00.
- MASK=0xFF, raise `src[5]` and `src[2]` in the same cycle → `irq`=1. `iack` → VECTOR=0x8000_0002 and PENDING=0x20. EOI → `irq` is 0 for one cycle, then 1. `iack` → VECTOR=0x8000_0005.
- Edge on `src[3]` with MASK=0 → PENDING=0x08, `irq` stays 0. Write MASK=0x08 → `irq`=1 two edges later. Write MASK=0 while in ASSERT → `irq`=0, state IDLE, PENDING still 0x08.
- W1C of bit 1 in the same cycle a new `src[1]` edge reaches PENDING → PENDING[1]=1. Separately, `iack` coinciding with a new edge on the winner → the bit stays 1 and VECTOR is still updated.
- In SERVICE, pulse `iack` and write EOI twice → the extra `iack` is ignored, the first EOI returns to IDLE, the second has no effect. Assert `reset`=0 while in ASSERT → `irq`=0 and all registers read 0 after release.
